// File: rtl/shift_reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_arb_pkg
//   Shared constants, the tag type carried alongside the 17-stage delay line,
//   and a saturating-increment helper used by the optional grant counters.
// -----------------------------------------------------------------------------
package shift_reg_arb_pkg;

    localparam int DW_C     = 16;  // delay-line data width
    localparam int STAGES_C = 17;  // delay-line depth

    // Requester identifiers as stored in the tag pipeline.
    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // One tag per delay-line stage: is the word real, and who sent it.
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage : shift_reg_arb_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant. Grants are combinational from the valids and
//   the last_grant register. last_grant moves only when a grant is actually
//   taken (advance=1). Reset leaves last_grant=1, so requester 0 wins the
//   first contention.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   v0, v1   in   request valids
//   advance  in   the current grant was accepted this cycle
//   g0, g1   out  one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic v0,
    input  logic v1,
    input  logic advance,
    output logic g0,
    output logic g1
);

    logic last_grant_q;
    logic last_grant_d;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        // On contention the requester that did not win last time goes next.
        g0           = v0 & (~v1 | last_grant_q);
        g1           = v1 & ~g0;
        last_grant_d = last_grant_q;
        if (advance) begin
            last_grant_d = g1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : rr_arb2

// File: rtl/shift_reg_arb.sv
// -----------------------------------------------------------------------------
// shift_reg_arb
//   Round-robin front end for the reset-less, stall-less shift_reg delay line.
//   Picks one of two valid/ready requesters per cycle, drives its word into
//   the delay line, and runs a {vld,id} tag pipeline of equal depth so each
//   word is steered back to its requester when it emerges STAGES cycles later.
//   Also keeps the in-flight count and implements a synchronous flush.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   req{0,1}_valid/data      requester words
//   req{0,1}_ready           word accepted this cycle (gated by flush and rst)
//   flush                    drop every in-flight word
//   sr_d_in / sr_d_out       to / from the delay line
//   out_data                 emerging word (straight from sr_d_out)
//   out{0,1}_valid           out_data belongs to requester 0 / 1
//   inflight, idle           valid words in the line; inflight==0
//
// Optional (macro SHIFT_REG_ARB_STATS_EN):
//   grant_cnt0, grant_cnt1   saturating accepted-transfer counts, cleared by
//                            rst only
// -----------------------------------------------------------------------------
module shift_reg_arb
    import shift_reg_arb_pkg::*;
#(
    parameter int DW     = DW_C,
    parameter int STAGES = STAGES_C,
    parameter int CW     = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          flush,
    output logic [DW-1:0] sr_d_in,
    input  logic [DW-1:0] sr_d_out,
    output logic [DW-1:0] out_data,
    output logic          out0_valid,
    output logic          out1_valid,
    output logic [CW-1:0] inflight,
    output logic          idle
`ifdef SHIFT_REG_ARB_STATS_EN
    ,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1
`endif
);

    logic          g0;
    logic          g1;
    logic          accept;
    logic          emerge;
    tag_t          tag_q [1:STAGES];
    tag_t          tag_d [1:STAGES];
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .v0      (req0_valid),
        .v1      (req1_valid),
        .advance (accept),
        .g0      (g0),
        .g1      (g1)
    );

    // Ready depends only on the valids (through the grant), never on the other
    // requester's ready, so no combinational loop can form through sources.
    assign req0_ready = g0 & ~flush & ~rst;
    assign req1_ready = g1 & ~flush & ~rst;
    assign accept     = req0_ready | req1_ready;
    assign emerge     = tag_q[STAGES].vld;

    // Idle cycles push zeros to keep toggling on the delay line down.
    always_comb begin
        sr_d_in = '0;
        if (req0_ready) begin
            sr_d_in = req0_data;
        end else if (req1_ready) begin
            sr_d_in = req1_data;
        end
    end

    // Tag pipeline next state; a flush drops every valid at the coming edge.
    always_comb begin
        tag_d[1].vld = accept;
        tag_d[1].id  = req1_ready ? ID_REQ1 : ID_REQ0;
        for (int k = 2; k <= STAGES; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        if (flush) begin
            for (int k = 1; k <= STAGES; k++) begin
                tag_d[k].vld = 1'b0;
            end
        end
    end

    // At most one word enters and one leaves per cycle, so the count never
    // exceeds STAGES and needs no overflow guard.
    always_comb begin
        inflight_d = inflight_q;
        case ({accept, emerge})
            2'b10:   inflight_d = inflight_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   inflight_d = inflight_q - {{(CW-1){1'b0}}, 1'b1};
            default: inflight_d = inflight_q;
        endcase
        if (flush) begin
            inflight_d = '0;
        end
    end

    // NOTE: the delay-line data is never reset; clearing the tag valids is
    // enough to mask whatever garbage it holds after power-up or a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) begin
                tag_q[k] <= '0;
            end
            inflight_q <= '0;
        end else begin
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    // An emerging word is still presented in a flush cycle; the flush only
    // affects what is left in the line after the edge.
    assign out_data   = sr_d_out;
    assign out0_valid = tag_q[STAGES].vld & (tag_q[STAGES].id == ID_REQ0);
    assign out1_valid = tag_q[STAGES].vld & (tag_q[STAGES].id == ID_REQ1);
    assign inflight   = inflight_q;
    assign idle       = (inflight_q == '0);

`ifdef SHIFT_REG_ARB_STATS_EN
    logic [15:0] grant_cnt0_q;
    logic [15:0] grant_cnt0_d;
    logic [15:0] grant_cnt1_q;
    logic [15:0] grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = req0_ready ? sat_inc16(grant_cnt0_q) : grant_cnt0_q;
        grant_cnt1_d = req1_ready ? sat_inc16(grant_cnt1_q) : grant_cnt1_q;
    end

    // Statistics survive a flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`else
    // Statistics disabled: no counters and no extra ports.
`endif

endmodule : shift_reg_arb
